// File: rtl/y_mux4_arbiter.sv
// y_mux4_arbiter: 4-way round-robin arbiter with a registered, ready/valid output word.
// Optional sticky-grant port "lock" is enabled by defining Y_MUX4_ARB_LOCK_EN.

module yMux4to1 #(
    parameter int SIZE = 32
) (
    input  logic [SIZE-1:0] a0,
    input  logic [SIZE-1:0] a1,
    input  logic [SIZE-1:0] a2,
    input  logic [SIZE-1:0] a3,
    input  logic [1:0]      c,
    output logic [SIZE-1:0] z
);
    always_comb begin
        case (c)
            2'd0:    z = a0;
            2'd1:    z = a1;
            2'd2:    z = a2;
            default: z = a3;
        endcase
    end
endmodule

module y_mux4_arbiter #(
    parameter int SIZE = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      req,
    input  logic [SIZE-1:0] a0,
    input  logic [SIZE-1:0] a1,
    input  logic [SIZE-1:0] a2,
    input  logic [SIZE-1:0] a3,
    input  logic            z_ready,
`ifdef Y_MUX4_ARB_LOCK_EN
    input  logic [3:0]      lock,
`endif
    output logic [SIZE-1:0] z,
    output logic            z_valid,
    output logic [1:0]      c,
    output logic [3:0]      gnt
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]      state;
    logic [1:0]      ptr;
    logic [1:0]      base;
    logic [1:0]      cand;
    logic [1:0]      next_c;
    logic [SIZE-1:0] mux_z;
    logic            busy;
    logic            handshake;
    logic            load;
    logic            lock_hold;

    assign busy      = (state == BUSY);
    assign handshake = busy && z_ready;
    assign load      = (!busy || z_ready) && (req != 4'b0000);

`ifdef Y_MUX4_ARB_LOCK_EN
    assign lock_hold = handshake && lock[c] && req[c];
`else
    assign lock_hold = 1'b0;
`endif

    // On a handshake the pointer becomes c before searching, so search from c directly.
    assign base = busy ? c : ptr;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        next_c = base;
        cand   = base;
        // Walk farthest-to-nearest so the closest requester after base wins last.
        for (int k = 4; k >= 1; k--) begin
            cand = base + 2'(k);
            if (req[cand]) next_c = cand;
        end
        if (lock_hold) next_c = c;
    end

    yMux4to1 #(.SIZE(SIZE)) u_mux (
        .a0 (a0),
        .a1 (a1),
        .a2 (a2),
        .a3 (a3),
        .c  (next_c),
        .z  (mux_z)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= 2'd3;
            z     <= '0;
            c     <= 2'd0;
            gnt   <= 4'b0000;
        end else begin
            if (handshake && !lock_hold) ptr <= c;
            if (load) begin
                state <= BUSY;
                z     <= mux_z;
                c     <= next_c;
                gnt   <= 4'b0001 << next_c;
            end else if (handshake) begin
                state <= IDLE;
                gnt   <= 4'b0000;
            end
        end
    end

    assign z_valid = busy;
endmodule

// File: tb/tb_y_mux4_arbiter.sv
// Self-checking bench for y_mux4_arbiter: directed vector table, corner sequences,
// and randomized traffic compared against a behavioural round-robin model.
`timescale 1ns/1ps

module tb_y_mux4_arbiter;
    localparam int SIZE = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0]      req;
    logic [SIZE-1:0] a0, a1, a2, a3;
    logic            z_ready;
`ifdef Y_MUX4_ARB_LOCK_EN
    logic [3:0]      lock;
`endif
    logic [SIZE-1:0] z;
    logic            z_valid;
    logic [1:0]      c;
    logic [3:0]      gnt;

    int n_cmp = 0;
    int n_bad = 0;

    y_mux4_arbiter #(.SIZE(SIZE)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .a0      (a0),
        .a1      (a1),
        .a2      (a2),
        .a3      (a3),
        .z_ready (z_ready),
`ifdef Y_MUX4_ARB_LOCK_EN
        .lock    (lock),
`endif
        .z       (z),
        .z_valid (z_valid),
        .c       (c),
        .gnt     (gnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic ev, input logic [1:0] ec,
                             input logic [3:0] eg, input logic [31:0] ez);
        check({tag, " z_valid"}, 64'(z_valid), 64'(ev));
        check({tag, " c"},       64'(c),       64'(ec));
        check({tag, " gnt"},     64'(gnt),     64'(eg));
        check({tag, " z"},       64'(z),       64'(ez));
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    bit          m_valid;
    int          m_c;
    int          m_ptr;
    logic [31:0] m_z;

    function automatic logic [31:0] data_of(input int i);
        case (i)
            0:       return a0;
            1:       return a1;
            2:       return a2;
            default: return a3;
        endcase
    endfunction

    function automatic int rr_winner(input int from);
        for (int off = 1; off <= 4; off++) begin
            if (req[(from + off) % 4]) return (from + off) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 0;
        m_c     = 0;
        m_ptr   = 3;
        m_z     = '0;
    endtask

    task automatic model_step();
        bit hold;
        int w;
        hold = 0;
`ifdef Y_MUX4_ARB_LOCK_EN
        hold = m_valid && z_ready && lock[m_c] && req[m_c];
`endif
        if (m_valid && !z_ready) return;
        if (m_valid && !hold) m_ptr = m_c;
        if (req == 4'b0000) begin
            m_valid = 0;
            return;
        end
        w       = hold ? m_c : rr_winner(m_ptr);
        m_valid = 1;
        m_c     = w;
        m_z     = data_of(w);
    endtask

    function automatic logic [3:0] model_gnt();
        return m_valid ? (4'b0001 << m_c) : 4'b0000;
    endfunction

    task automatic do_reset();
        rst_n   = 1'b0;
        req     = 4'b0000;
        z_ready = 1'b0;
`ifdef Y_MUX4_ARB_LOCK_EN
        lock    = 4'b0000;
`endif
        cycle();
        cycle();
        rst_n = 1'b1;
        model_reset();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [3:0]  req;
        logic        zr;
        logic        ev;
        logic [1:0]  ec;
        logic [31:0] ez;
    } vec_t;

    vec_t tbl[16];

    initial begin
        tbl[0]  = '{4'b1111, 1'b1, 1'b1, 2'd0, 32'h0000_00A0};
        tbl[1]  = '{4'b1111, 1'b1, 1'b1, 2'd1, 32'h0000_00A1};
        tbl[2]  = '{4'b1111, 1'b1, 1'b1, 2'd2, 32'h0000_00A2};
        tbl[3]  = '{4'b1111, 1'b1, 1'b1, 2'd3, 32'h0000_00A3};
        tbl[4]  = '{4'b1111, 1'b1, 1'b1, 2'd0, 32'h0000_00A0};
        tbl[5]  = '{4'b1111, 1'b1, 1'b1, 2'd1, 32'h0000_00A1};
        tbl[6]  = '{4'b1111, 1'b1, 1'b1, 2'd2, 32'h0000_00A2};
        tbl[7]  = '{4'b1111, 1'b1, 1'b1, 2'd3, 32'h0000_00A3};
        tbl[8]  = '{4'b1001, 1'b1, 1'b1, 2'd0, 32'h0000_00A0};
        tbl[9]  = '{4'b1001, 1'b1, 1'b1, 2'd3, 32'h0000_00A3};
        tbl[10] = '{4'b1001, 1'b1, 1'b1, 2'd0, 32'h0000_00A0};
        tbl[11] = '{4'b0000, 1'b1, 1'b0, 2'd0, 32'h0000_00A0};
        tbl[12] = '{4'b0000, 1'b1, 1'b0, 2'd0, 32'h0000_00A0};
        tbl[13] = '{4'b0010, 1'b0, 1'b1, 2'd1, 32'h0000_00A1};
        tbl[14] = '{4'b0001, 1'b0, 1'b1, 2'd1, 32'h0000_00A1};
        tbl[15] = '{4'b0001, 1'b1, 1'b1, 2'd0, 32'h0000_00A0};

        // Reset state, observed without any clock edge.
        rst_n   = 1'b0;
        req     = 4'b0000;
        z_ready = 1'b0;
        a0 = '0; a1 = '0; a2 = '0; a3 = '0;
`ifdef Y_MUX4_ARB_LOCK_EN
        lock    = 4'b0000;
`endif
        #1;
        check_out("reset", 1'b0, 2'd0, 4'b0000, 32'h0);

        // Round-robin rotation, wrap, idle return and backpressure from the table.
        do_reset();
        a0 = 32'h0000_00A0; a1 = 32'h0000_00A1; a2 = 32'h0000_00A2; a3 = 32'h0000_00A3;
        for (int i = 0; i < 16; i++) begin
            req     = tbl[i].req;
            z_ready = tbl[i].zr;
            cycle();
            check_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ec,
                      tbl[i].ev ? (4'b0001 << tbl[i].ec) : 4'b0000, tbl[i].ez);
        end

        // Idle with no requests: nothing captured whatever the data does.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            a0 = $urandom; a1 = $urandom; a2 = $urandom; a3 = $urandom;
            cycle();
            check_out($sformatf("idle%0d", i), 1'b0, 2'd0, 4'b0000, 32'h0);
        end

        // Backpressure: captured word survives data change and dropped req.
        do_reset();
        a2      = 32'hDEAD_BEEF;
        req     = 4'b0100;
        z_ready = 1'b0;
        cycle();
        check_out("bp_cap", 1'b1, 2'd2, 4'b0100, 32'hDEAD_BEEF);
        a2 = 32'h1234_5678;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) req = 4'b0000;
            cycle();
            check_out($sformatf("bp_hold%0d", i), 1'b1, 2'd2, 4'b0100, 32'hDEAD_BEEF);
        end
        z_ready = 1'b1;
        cycle();
        check_out("bp_accept", 1'b0, 2'd2, 4'b0000, 32'hDEAD_BEEF);

        // Reset while a word is pending, then restart from requester 0.
        do_reset();
        a0 = 32'h0000_00A0; a1 = 32'h0000_00A1; a2 = 32'h0000_00A2; a3 = 32'h0000_00A3;
        req     = 4'b1111;
        z_ready = 1'b1;
        cycle();
        cycle();
        z_ready = 1'b0;
        check_out("mid_pre", 1'b1, 2'd1, 4'b0010, 32'h0000_00A1);
        rst_n = 1'b0;
        #2;
        check_out("mid_rst", 1'b0, 2'd0, 4'b0000, 32'h0);
        rst_n   = 1'b1;
        z_ready = 1'b1;
        cycle();
        check_out("mid_first", 1'b1, 2'd0, 4'b0001, 32'h0000_00A0);

`ifdef Y_MUX4_ARB_LOCK_EN
        // Lock keeps requester 0 granted until lock drops.
        do_reset();
        req     = 4'b0011;
        lock    = 4'b0001;
        z_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check_out($sformatf("lock%0d", i), 1'b1, 2'd0, 4'b0001, 32'h0000_00A0);
        end
        lock = 4'b0000;
        cycle();
        check_out("unlock", 1'b1, 2'd1, 4'b0010, 32'h0000_00A1);
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            req     = 4'($urandom);
            z_ready = ($urandom_range(0, 3) != 0);
            a0 = $urandom; a1 = $urandom; a2 = $urandom; a3 = $urandom;
`ifdef Y_MUX4_ARB_LOCK_EN
            lock = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
`endif
            model_step();
            cycle();
            check_out($sformatf("rnd%0d", i), m_valid, 2'(m_c), model_gnt(), m_z);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/y_mux4_arbiter.md
Y_MUX4_ARBITER -- requirements
Module: y_mux4_arbiter

Interface
REQ-001 SHALL have parameter SIZE, default 32, giving the data width of each requester and of the output.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port req, input, 4 bits: req[i] high means requester i has data on ai.
REQ-005 SHALL have ports a0, a1, a2, a3, input, SIZE bits each: requester data.
REQ-006 SHALL have port z_ready, input, 1 bit: downstream accepts z when high.
REQ-007 SHALL have port lock, input, 4 bits: lock[i] lets granted requester i retain the grant; present only under the Configuration macro.
REQ-008 SHALL have port z, output, SIZE bits: registered, selected data.
REQ-009 SHALL have port z_valid, output, 1 bit: z holds an unaccepted word.
REQ-010 SHALL have port c, output, 2 bits: index of the current or last winner, i.e. the mux select.
REQ-011 SHALL have port gnt, output, 4 bits: one-hot grant, high only while z_valid.

Function
REQ-012 SHALL select data through an internal yMux4to1 #(SIZE) instance, driven by the next-grant index.
REQ-013 SHALL implement a two-state FSM:
- IDLE: z_valid=0.
- BUSY: z_valid=1.
REQ-014 In IDLE with req!=0, SHALL on the next edge:
- choose the winner by round-robin, searching from ptr+1 mod 4 upward;
- capture the winner's ai into z;
- set c, gnt, z_valid=1;
- go to BUSY.
Latency from req to z_valid is 1 cycle.
REQ-015 In BUSY with z_ready=0, SHALL hold z, c, gnt and z_valid stable regardless of req or ai changes.
REQ-016 In BUSY with z_ready=1 (handshake), SHALL set ptr to c and then:
- if req!=0, capture the next round-robin winner on the same edge and stay in BUSY (throughput of 1 word/cycle);
- otherwise go to IDLE with gnt=0, while z and c keep their last values.
REQ-017 SHALL treat the round-robin search as wrapping (3 -> 0); a sole requester SHALL win repeatedly.
REQ-018 SHALL not be affected by a requester deasserting req after capture; the captured word still completes its handshake.
REQ-019 SHALL ignore req and data in IDLE when req==0; z_valid stays 0.

Reset
REQ-020 SHALL, while rst_n=0, asynchronously force:
- state=IDLE, z=0, z_valid=0, gnt=0, c=0;
- ptr=3, so requester 0 wins first after reset.
REQ-021 SHALL discard any unaccepted word on reset mid-operation and resume arbitration from ptr=3 on the first edge after rst_n rises.

Configuration
REQ-022 SHALL use the macro Y_MUX4_ARB_LOCK_EN to control the lock feature, as follows.
- Defined: the lock port exists. At a handshake, if lock[c]=1 and req[c]=1, the same requester is re-granted (ptr unchanged) regardless of other requests.
- Undefined: the lock port is absent and behaviour is pure round-robin.

Verification
REQ-023 Reset, then req=4'b1111 with a0..a3=32'h0000_00A0, 32'h0000_00A1, 32'h0000_00A2, 32'h0000_00A3, and z_ready=1 -> z sequence A0, A1, A2, A3, A0 on consecutive cycles; c = 0, 1, 2, 3, 0; gnt one-hot matching.
REQ-024 Backpressure: req=4'b0100, a2=32'hDEAD_BEEF, z_ready=0 for 5 cycles, with a2 changed to 32'h1234_5678 after capture -> z stays DEAD_BEEF, z_valid=1, gnt=4'b0100 throughout; accepted on the first z_ready=1.
REQ-025 Wrap: last grant c=3, then req=4'b1001 -> next winner 0, then 3.
REQ-026 Reset mid-operation: rst_n=0 while z_valid=1 -> z_valid, gnt, z, c go to 0 immediately without a clock; after release with req=4'b1111, the first winner is 0.
REQ-027 With Y_MUX4_ARB_LOCK_EN defined: req=4'b0011, lock=4'b0001, z_ready=1 -> requester 0 granted every cycle; dropping lock -> next grant goes to 1.
REQ-028 Idle: req=0 for 10 cycles after reset -> z_valid=0, gnt=0, z=0.
